alu_seq: RTL and testbench

Handshaked, multi-cycle successor to the combinational ALU, parametrised in word width. Single-cycle logic/arithmetic ops complete in one clock, while iterative multiply and, optionally, divide run one bit per clock. A simple valid/ready protocol on both sides lets it sit between the operand source (switch/register front end) and the result sink (LED/HEX display or register writeback).

---
 rtl/alu_seq_if.sv | 26 ++
 rtl/alu_seq.sv | 191 +++++++++++++++++++
 tb/tb_alu_seq.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq: valid/ready on the operand side and on the result side.
interface alu_seq_if #(
    parameter int WORD_SIZE = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WORD_SIZE-1:0] in_a;
    logic [WORD_SIZE-1:0] in_b;
    logic [2:0]           in_op;
    logic                 out_valid;
    logic                 out_ready;
    logic [WORD_SIZE-1:0] out_result;
    logic                 out_carry;
    logic                 out_zero;
    logic                 out_err;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_result, out_carry, out_zero, out_err
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_result, out_carry, out_zero, out_err
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked multi-cycle ALU: one-clock logic/arithmetic, bit-serial multiply and optional
// restoring divide (enabled by defining ALU_SEQ_DIV_EN).
module alu_seq #(
    parameter  int WORD_SIZE = 16,
    localparam int CNT_W     = $clog2(WORD_SIZE) + 1
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    alu_seq_if.slave   bus
);
    localparam int SH_W = $clog2(WORD_SIZE);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_DIV = 3'b111;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state_q, state_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [WORD_SIZE-1:0] result_q, result_d;
    logic                 carry_q, carry_d;
    logic                 zero_q, zero_d;
    logic                 err_q, err_d;
    logic [WORD_SIZE-1:0] a_q, a_d;
    logic [WORD_SIZE-1:0] b_q, b_d;
    logic [WORD_SIZE-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 go_busy;
    logic [WORD_SIZE-1:0] mul_nxt;
    logic [WORD_SIZE+1:0] single_res;
`ifdef ALU_SEQ_DIV_EN
    logic                 is_div_q, is_div_d;
    logic [WORD_SIZE:0]   rem_q, rem_d;
    logic [WORD_SIZE:0]   rem_t;
`endif

    // Returns {err, carry, result} for every op that finishes in one clock.
    function automatic logic [WORD_SIZE+1:0] single_op(input logic [WORD_SIZE-1:0] a,
                                                       input logic [WORD_SIZE-1:0] b,
                                                       input logic [2:0] op);
        logic [WORD_SIZE:0] sum;
        logic               err;
        sum = '0;
        err = 1'b0;
        case (op)
            OP_ADD: sum = {1'b0, a} + {1'b0, b};
            OP_SUB: sum = {1'b0, a} + {1'b0, ~b} + (WORD_SIZE+1)'(1);
            OP_AND: sum = {1'b0, a & b};
            OP_OR:  sum = {1'b0, a | b};
            OP_XOR: sum = {1'b0, a ^ b};
            OP_SLL: sum = {1'b0, a << b[SH_W-1:0]};
`ifdef ALU_SEQ_DIV_EN
            OP_DIV: begin
                sum = {1'b0, {WORD_SIZE{1'b1}}};
                err = 1'b1;
            end
`else
            OP_DIV: begin
                sum = '0;
                err = 1'b1;
            end
`endif
            default: sum = '0;
        endcase
        return {err, sum};
    endfunction

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        carry_d     = carry_q;
        err_d       = err_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        mul_nxt     = acc_q + (b_q[0] ? a_q : '0);
        single_res  = single_op(bus.in_a, bus.in_b, bus.in_op);
`ifdef ALU_SEQ_DIV_EN
        is_div_d    = is_div_q;
        rem_d       = rem_q;
        rem_t       = {rem_q[WORD_SIZE-1:0], a_q[WORD_SIZE-1]};
        go_busy     = (bus.in_op == OP_MUL) || (bus.in_op == OP_DIV && bus.in_b != '0);
`else
        go_busy     = (bus.in_op == OP_MUL);
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_d   = bus.in_a;
                    b_d   = bus.in_b;
                    acc_d = '0;
                    cnt_d = CNT_W'(WORD_SIZE);
`ifdef ALU_SEQ_DIV_EN
                    is_div_d = (bus.in_op == OP_DIV);
                    rem_d    = '0;
`endif
                    if (go_busy) begin
                        state_d = BUSY;
                    end else begin
                        result_d = single_res[WORD_SIZE-1:0];
                        carry_d  = single_res[WORD_SIZE];
                        err_d    = single_res[WORD_SIZE+1];
                        state_d  = DONE;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                acc_d = mul_nxt;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
`ifdef ALU_SEQ_DIV_EN
                // Restoring divide: dividend shifts out of a_q MSB, quotient bits shift in at LSB.
                if (is_div_q) begin
                    b_d = b_q;
                    if (rem_t >= {1'b0, b_q}) begin
                        rem_d = rem_t - {1'b0, b_q};
                        a_d   = {a_q[WORD_SIZE-2:0], 1'b1};
                    end else begin
                        rem_d = rem_t;
                        a_d   = {a_q[WORD_SIZE-2:0], 1'b0};
                    end
                end
`endif
                if (cnt_q == CNT_W'(1)) begin
                    result_d = mul_nxt;
`ifdef ALU_SEQ_DIV_EN
                    if (is_div_q) result_d = a_d;
`endif
                    carry_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        zero_d      = (result_d == '0);
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            err_q       <= err_d;
        end
    end

    // Datapath registers carry no reset; they are always loaded on accept before use.
    always_ff @(posedge CLOCK_50) begin
        a_q   <= a_d;
        b_q   <= b_d;
        acc_q <= acc_d;
        cnt_q <= cnt_d;
`ifdef ALU_SEQ_DIV_EN
        is_div_q <= is_div_d;
        rem_q    <= rem_d;
`endif
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = result_q;
    assign bus.out_carry  = carry_q;
    assign bus.out_zero   = zero_q;
    assign bus.out_err    = err_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WORD_SIZE=16; define ALU_SEQ_DIV_EN to cover the divider.
module tb_alu_seq;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fails;

    alu_seq_if #(.WORD_SIZE(16)) bus ();

    alu_seq #(.WORD_SIZE(16)) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge with the unit idle; returns cycles from accept to out_valid.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                         output int lat);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_op    = op;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_out(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, "_idle_rdy"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_idle_vld"}, 32'(bus.out_valid), 32'd0);
    endtask

    task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] op, input logic [15:0] exp_r, input logic exp_c,
                       input logic exp_z, input logic exp_e, input int exp_lat);
        int lat;
        issue(a, b, op, lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, 32'(bus.out_result), 32'(exp_r));
        check({tag, "_c"}, 32'(bus.out_carry), 32'(exp_c));
        check({tag, "_z"}, 32'(bus.out_zero), 32'(exp_z));
        check({tag, "_e"}, 32'(bus.out_err), 32'(exp_e));
        release_out(tag);
    endtask

    initial begin
        int lat;
        int vld_seen;
        n_tests       = 0;
        n_fails       = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_a      = 16'h1234;
        bus.in_b      = 16'h0001;
        bus.in_op     = 3'b000;
        bus.out_ready = 1'b0;

        // Reset held with in_valid asserted: nothing may be accepted
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy", 32'(bus.in_ready), 32'd0);
        check("rst_vld", 32'(bus.out_valid), 32'd0);
        check("rst_res", 32'(bus.out_result), 32'd0);
        check("rst_flags", {29'd0, bus.out_carry, bus.out_zero, bus.out_err}, 32'd0);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_rdy", 32'(bus.in_ready), 32'd1);
        check("post_rst_vld", 32'(bus.out_valid), 32'd0);

        run("add_carry", 16'hFFFF, 16'h0001, 3'b000, 16'h0000, 1'b1, 1'b1, 1'b0, 1);
        run("sub_pos",   16'h0005, 16'h0003, 3'b001, 16'h0002, 1'b1, 1'b0, 1'b0, 1);
        run("and",       16'hF0F0, 16'h3C3C, 3'b010, 16'h3030, 1'b0, 1'b0, 1'b0, 1);
        run("or",        16'hF0F0, 16'h0F01, 3'b011, 16'hFFF1, 1'b0, 1'b0, 1'b0, 1);
        run("xor",       16'hAAAA, 16'hFFFF, 3'b100, 16'h5555, 1'b0, 1'b0, 1'b0, 1);
        run("sll",       16'h0001, 16'h0013, 3'b101, 16'h0008, 1'b0, 1'b0, 1'b0, 1);
        run("mul_ovf",   16'hFFFF, 16'hFFFF, 3'b110, 16'h0001, 1'b0, 1'b0, 1'b0, 17);

        // MUL followed by five cycles of backpressure
        issue(16'h0123, 16'h0010, 3'b110, lat);
        check("mul_lat", 32'(lat), 32'd17);
        check("mul_res", 32'(bus.out_result), 32'h1230);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_vld", 32'(bus.out_valid), 32'd1);
            check("bp_rdy", 32'(bus.in_ready), 32'd0);
            check("bp_res", 32'(bus.out_result), 32'h1230);
            check("bp_flags", {29'd0, bus.out_carry, bus.out_zero, bus.out_err}, 32'd0);
        end
        release_out("bp");

`ifdef ALU_SEQ_DIV_EN
        run("div",  16'd1000, 16'd7, 3'b111, 16'd142, 1'b0, 1'b0, 1'b0, 17);
        run("div0", 16'd5,    16'd0, 3'b111, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1);
`else
        run("div_off", 16'd1000, 16'd7, 3'b111, 16'h0000, 1'b0, 1'b1, 1'b1, 1);
`endif

        // Reset during MUL: the dropped op must never raise out_valid
        vld_seen     = 0;
        bus.in_a     = 16'h0123;
        bus.in_b     = 16'h0010;
        bus.in_op    = 3'b110;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) vld_seen++;
        end
        rst_n = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) vld_seen++;
        end
        check("midrst_rdy", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) vld_seen++;
        end
        check("midrst_novld", 32'(vld_seen), 32'd0);
        check("midrst_idle", 32'(bus.in_ready), 32'd1);
        run("sub_neg", 16'h0003, 16'h0005, 3'b001, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end
endmodule
